// File: rtl/gps_ca_pkg.sv
// GPS L1 C/A code constants, G2 phase-select table and helpers.
// Shared by the LFSR cell and the channel code generator.
package gps_ca_pkg;

  localparam int CA_LEN = 1023;
  localparam int LFSR_W = 10;

  localparam logic [LFSR_W-1:0] LFSR_INIT = '1;

  // bit i holds stage i+1
  localparam logic [LFSR_W-1:0] G1_TAPS = 10'h204;
  localparam logic [LFSR_W-1:0] G2_TAPS = 10'h3A6;

  typedef logic [5:0] prn_t;

  // {tapA, tapB} G2 stage numbers, index = PRN-1
  localparam logic [7:0] G2_SEL [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59,
    8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56,
    8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47,
    8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A,
    8'h16, 8'h27, 8'h38, 8'h49
  };

  function automatic logic prn_valid(prn_t p);
    return (p != 6'd0) && (p <= 6'd32);
  endfunction

  function automatic logic ca_chip(
    logic [LFSR_W-1:0] g1,
    logic [LFSR_W-1:0] g2,
    prn_t              p
  );
    logic [4:0] i;
    logic [3:0] a;
    logic [3:0] b;
    i = 5'(p - 6'd1);
    a = G2_SEL[i][7:4] - 4'd1;
    b = G2_SEL[i][3:0] - 4'd1;
    return g1[LFSR_W-1] ^ g2[a] ^ g2[b];
  endfunction

endpackage

// File: rtl/ca_lfsr10.sv
// 10-stage Fibonacci LFSR, stage 1 in bit 0.
// reinit reloads all-ones and takes priority over step.
module ca_lfsr10
  import gps_ca_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS = G1_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              reinit,
  output logic [LFSR_W-1:0] q
);

  logic fb;

  assign fb = ^(q & TAPS);

  // shift toward stage 10, feedback into stage 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_INIT;
    end else if (reinit) begin
      q <= LFSR_INIT;
    end else if (step) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// C/A Gold code generator for one channel: E/P/L chips at
// half-chip spacing, chip index and epoch strobe.
module ca_code_gen
  import gps_ca_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       prn_sel,
  input  logic             load,
  input  logic             half_chip_tick,
  output logic             early,
  output logic             prompt,
  output logic             late,
  output logic [IDX_W-1:0] chip_idx,
  output logic             epoch,
  output logic             active,
  output logic             prn_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(CA_LEN - 1);

  logic [LFSR_W-1:0] g1;
  logic [LFSR_W-1:0] g2;
  prn_t              prn_q;
  logic              half_q;
  logic [IDX_W-1:0]  idx_q;
  logic              prompt_q;
  logic              late_q;
  logic              epoch_q;
  logic              active_q;
  logic              err_q;

  logic load_ok;
  logic tick_en;
  logic adv;
  logic wrap;

  assign load_ok = load & prn_valid(prn_sel);
  assign tick_en = half_chip_tick & active_q & ~load;
  assign adv     = tick_en & half_q;
  assign wrap    = adv & (idx_q == LAST);

  ca_lfsr10 #(.TAPS(G1_TAPS)) u_g1 (
    .clk    (clk),
    .rst    (rst),
    .step   (adv & ~wrap),
    .reinit (load_ok | wrap),
    .q      (g1)
  );

  ca_lfsr10 #(.TAPS(G2_TAPS)) u_g2 (
    .clk    (clk),
    .rst    (rst),
    .step   (adv & ~wrap),
    .reinit (load_ok | wrap),
    .q      (g2)
  );

  // load restarts or kills the channel; ticks shift E->P->L and advance chips
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prn_q    <= '0;
      half_q   <= 1'b0;
      idx_q    <= '0;
      prompt_q <= 1'b0;
      late_q   <= 1'b0;
      epoch_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      epoch_q <= wrap;
      if (load) begin
        prompt_q <= 1'b0;
        late_q   <= 1'b0;
        active_q <= load_ok;
        err_q    <= ~load_ok;
        if (load_ok) begin
          prn_q  <= prn_sel;
          half_q <= 1'b0;
          idx_q  <= '0;
        end
      end else if (tick_en) begin
        late_q   <= prompt_q;
        prompt_q <= early;
        half_q   <= ~half_q;
        if (adv) begin
          idx_q <= wrap ? '0 : idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign early    = active_q & ca_chip(g1, g2, prn_q);
  assign prompt   = prompt_q;
  assign late     = late_q;
  assign chip_idx = idx_q;
  assign epoch    = epoch_q;
  assign active   = active_q;
  assign prn_err  = err_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// Scoreboard bench for ca_code_gen: stimulus pushes expected
// outputs, a negedge monitor pops and compares.
module tb_ca_code_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] prn_sel = '0;
  logic       load = 1'b0;
  logic       half_chip_tick = 1'b0;
  logic       early;
  logic       prompt;
  logic       late;
  logic [9:0] chip_idx;
  logic       epoch;
  logic       active;
  logic       prn_err;

  ca_code_gen dut (
    .clk            (clk),
    .rst            (rst),
    .prn_sel        (prn_sel),
    .load           (load),
    .half_chip_tick (half_chip_tick),
    .early          (early),
    .prompt         (prompt),
    .late           (late),
    .chip_idx       (chip_idx),
    .epoch          (epoch),
    .active         (active),
    .prn_err        (prn_err)
  );

  always #5 clk = ~clk;

  localparam int TAP_A [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,
                                1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  localparam int TAP_B [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,
                                4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  logic [15:0] sb[$];
  string       tq[$];
  int checks = 0;
  int errors = 0;

  logic [1022:0] code = '0;
  int m_idx = 0;
  bit m_half = 0;
  bit m_p = 0;
  bit m_l = 0;
  bit m_act = 0;
  bit m_err = 0;

  function automatic logic [1022:0] gold(int prn);
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1;
    bit f2;
    logic [1022:0] c;
    for (int k = 1; k <= 10; k++) begin
      g1[k] = 1;
      g2[k] = 1;
    end
    for (int i = 0; i < 1023; i++) begin
      c[i] = g1[10] ^ g2[TAP_A[prn-1]] ^ g2[TAP_B[prn-1]];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k >= 2; k--) begin
        g1[k] = g1[k-1];
        g2[k] = g2[k-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
    return c;
  endfunction

  function automatic logic [15:0] pack(bit ep);
    logic e;
    e = m_act ? code[m_idx] : 1'b0;
    return {e, m_p, m_l, 10'(m_idx), ep, m_act, m_err};
  endfunction

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask

  // one clock of stimulus followed by the expected post-edge outputs
  task automatic step(bit ld, int p, bit tk, string tag);
    bit ep;
    bit e;
    @(negedge clk);
    load = ld;
    prn_sel = 6'(p);
    half_chip_tick = tk;
    @(posedge clk);
    ep = 0;
    if (ld) begin
      m_p = 0;
      m_l = 0;
      if (p >= 1 && p <= 32) begin
        code = gold(p);
        m_idx = 0;
        m_half = 0;
        m_act = 1;
        m_err = 0;
      end else begin
        m_act = 0;
        m_err = 1;
      end
    end else if (tk && m_act) begin
      e = code[m_idx];
      m_l = m_p;
      m_p = e;
      if (m_half) begin
        if (m_idx == 1022) begin
          m_idx = 0;
          ep = 1;
        end else begin
          m_idx++;
        end
      end
      m_half = !m_half;
    end
    sb.push_back(pack(ep));
    tq.push_back(tag);
    #1;
    load = 0;
    half_chip_tick = 0;
  endtask

  // samples early at the start of each chip, two ticks per chip
  task automatic read_chips(output logic [9:0] v, input int gap);
    for (int k = 0; k < 10; k++) begin
      v[9-k] = early;
      step(0, 0, 1, "chips");
      for (int g = 0; g < gap; g++) step(0, 0, 0, "gap");
      step(0, 0, 1, "chips");
    end
  endtask

  function automatic void reset_model();
    m_idx = 0;
    m_half = 0;
    m_p = 0;
    m_l = 0;
    m_act = 0;
    m_err = 0;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [15:0] x;
      logic [15:0] g;
      string t;
      x = sb.pop_front();
      t = tq.pop_front();
      g = {early, prompt, late, chip_idx, epoch, active, prn_err};
      checks++;
      if (g !== x) begin
        errors++;
        $display("FAIL %s got e%b p%b l%b idx%0d ep%b act%b err%b expected e%b p%b l%b idx%0d ep%b act%b err%b",
                 t, g[15], g[14], g[13], g[12:3], g[2], g[1], g[0],
                 x[15], x[14], x[13], x[12:3], x[2], x[1], x[0]);
      end
    end
  end

  initial begin
    logic [9:0] v;
    int ep_cnt;
    int ones;
    int ep_at;

    sb.push_back(16'h0);
    tq.push_back("reset");
    @(negedge clk);
    #2 rst = 1'b1;

    step(0, 0, 1, "idle_tick");
    step(0, 0, 0, "idle");

    step(1, 1, 0, "load1");
    read_chips(v, 0);
    chk("prn1_first10", int'(v), int'(10'o1440));
    chk("prn1_idx10", int'(chip_idx), 10);
    chk("prn1_active", int'(active), 1);

    step(1, 2, 0, "load2");
    read_chips(v, 1);
    chk("prn2_first10", int'(v), int'(10'o1620));

    step(1, 1, 0, "load1_epoch");
    ep_cnt = 0;
    ones = int'(early);
    ep_at = -1;
    for (int i = 1; i <= 2046; i++) begin
      step(0, 0, 1, "epoch_run");
      if (epoch) begin
        ep_cnt++;
        ep_at = i;
      end
      if (i % 2 == 0 && i < 2046) ones += int'(early);
    end
    chk("epoch_count", ep_cnt, 1);
    chk("epoch_tick", ep_at, 2046);
    chk("epoch_ones", ones, 512);
    read_chips(v, 0);
    chk("epoch2_first10", int'(v), int'(10'o1440));

    step(1, 0, 0, "bad_prn0");
    step(0, 0, 1, "bad_tick");
    step(0, 0, 1, "bad_tick");
    step(1, 40, 1, "bad_prn40");
    for (int i = 0; i < 4; i++) step(0, 0, 1, "bad_tick");
    chk("err_flag", int'(prn_err), 1);
    step(1, 5, 0, "load5");
    chk("err_clear", int'(prn_err), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, "prn5_run");

    step(1, 3, 0, "load3");
    for (int i = 0; i < 1000; i++) step(0, 0, 1, "to500");
    chk("mid_idx500", int'(chip_idx), 500);
    step(1, 3, 1, "load_tick");
    chk("load_tick_idx", int'(chip_idx), 0);
    for (int i = 0; i < 1000; i++) step(0, 0, 1, "to500b");

    @(posedge clk);
    #2 rst = 1'b0;
    reset_model();
    sb.push_back(16'h0);
    tq.push_back("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    step(0, 0, 1, "post_rst_tick");
    step(1, 4, 0, "load4");
    for (int i = 0; i < 6; i++) step(0, 0, 1, "prn4_run");

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
